// File: rtl/stopwatch_core.sv
// Stopwatch time base: 1/100 s prescaler, SS.cc BCD counter and a
// multiplexed common-anode seven-segment scan driver.
module stopwatch_core #(
   parameter int TICK_DIV = 500000,
   parameter int SCAN_DIV = 50000
) (
   input  logic        mclk,
   input  logic        rst,
   input  logic        en,
   input  logic        clr,
   output logic [15:0] digits,
   output logic        ovf,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PW-1:0] pcnt;
   logic [SW-1:0] scnt;
   logic [1:0]    sel;
   logic [3:0]    sec_tens, sec_ones, hund_tens, hund_ones;
   logic [3:0]    cur_digit;
   logic          tick;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   assign tick   = en && !clr && (pcnt == PW'(TICK_DIV - 1));
   assign digits = {sec_tens, sec_ones, hund_tens, hund_ones};

   // Prescaler and BCD chain; clr beats a coincident tick, pause keeps pcnt.
   always_ff @(posedge mclk) begin
      if (rst || clr) begin
         pcnt      <= '0;
         sec_tens  <= 4'd0;
         sec_ones  <= 4'd0;
         hund_tens <= 4'd0;
         hund_ones <= 4'd0;
         ovf       <= 1'b0;
      end else begin
         ovf <= 1'b0;
         if (tick) begin
            pcnt <= '0;
            if (hund_ones != 4'd9) begin
               hund_ones <= hund_ones + 4'd1;
            end else begin
               hund_ones <= 4'd0;
               if (hund_tens != 4'd9) begin
                  hund_tens <= hund_tens + 4'd1;
               end else begin
                  hund_tens <= 4'd0;
                  if (sec_ones != 4'd9) begin
                     sec_ones <= sec_ones + 4'd1;
                  end else begin
                     sec_ones <= 4'd0;
                     if (sec_tens != 4'd5) begin
                        sec_tens <= sec_tens + 4'd1;
                     end else begin
                        sec_tens <= 4'd0;
                        ovf      <= 1'b1;
                     end
                  end
               end
            end
         end else if (en) begin
            pcnt <= pcnt + PW'(1);
         end
      end
   end

   always_comb begin
      cur_digit = 4'd0;
      case (sel)
         2'd0: cur_digit = hund_ones;
         2'd1: cur_digit = hund_tens;
         2'd2: cur_digit = sec_ones;
         2'd3: cur_digit = sec_tens;
         default: cur_digit = 4'd0;
      endcase
   end

   // Free-running scan; an/seg/dp register the current sel so they move together.
   always_ff @(posedge mclk) begin
      if (rst) begin
         scnt <= '0;
         sel  <= 2'd0;
         an   <= 4'b1110;
         seg  <= 7'b1000000;
         dp   <= 1'b1;
      end else begin
         if (scnt == SW'(SCAN_DIV - 1)) begin
            scnt <= '0;
            sel  <= sel + 2'd1;
         end else begin
            scnt <= scnt + SW'(1);
         end
         an  <= ~(4'b0001 << sel);
         seg <= seg7(cur_digit);
         dp  <= (sel != 2'd2);
      end
   end

endmodule
